// File: rtl/scroll_pkg.sv
// scroll_pkg: shared types, speed encodings and width helper for the scrolling-message engine.
package scroll_pkg;
  typedef enum logic [1:0] {IDLE, EDIT, SCROLL, HOLD} scroll_state_t;
  localparam logic [1:0] SPD_X1 = 2'b00;
  localparam logic [1:0] SPD_X2 = 2'b01;
  localparam logic [1:0] SPD_X4 = 2'b10;
  localparam logic [1:0] SPD_X8 = 2'b11;
  function automatic int ptr_w(input int depth, input int gap);
    return (depth + gap) > 1 ? $clog2(depth + gap) : 1;
  endfunction
endpackage

// File: rtl/scroll_step_gen.sv
// scroll_step_gen: TICK_M prescaler plus 2^speed divider producing one-cycle scroll step pulses.
module scroll_step_gen
  import scroll_pkg::*;
#(
  parameter int TICK_M = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run_en,
  input  logic       hold,
  input  logic [1:0] speed,
  output logic       step
);
  localparam int CW = TICK_M > 1 ? $clog2(TICK_M) : 1;
  logic [CW-1:0] pre;
  logic [2:0] div, lim;
  logic [1:0] spd_q;
  logic tick;
  assign tick = run_en && pre == CW'(TICK_M - 1);
  assign lim = spd_q == SPD_X1 ? 3'd0 : spd_q == SPD_X2 ? 3'd1 : spd_q == SPD_X4 ? 3'd3 : 3'd7;
  assign step = tick && div == lim;
  // Speed is latched only at a divider wrap so a change never shortens a step in progress.
  always_ff @(posedge clk)
    if (reset || !(run_en || hold)) begin
      pre <= '0;
      div <= '0;
      spd_q <= speed;
    end else if (run_en) begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) div <= step ? '0 : div + 1'b1;
      if (step) spd_q <= speed;
    end
endmodule

// File: rtl/scroll_msg_ctrl.sv
// scroll_msg_ctrl: message buffer, edit/scroll FSM and display window for the seven-segment path.
module scroll_msg_ctrl
  import scroll_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int DEPTH  = 16,
  parameter int DW     = 4,
  parameter int GAP    = 2,
  parameter int TICK_M = 100000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [DW-1:0]              wr_data,
  input  logic                       clear,
  input  logic                       run,
  input  logic                       pause,
  input  logic                       dir,
  input  logic [1:0]                 speed,
  output logic [DIGITS*DW-1:0]       disp_val,
  output logic [DIGITS-1:0]          digit_en,
  output logic [$clog2(DEPTH+1)-1:0] msg_len,
  output logic                       full,
  output logic                       empty,
  output logic                       scrolling,
  output logic                       wr_rej
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = ptr_w(DEPTH, GAP);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  scroll_state_t state, nxt;
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] ptr, ptr_nxt, last;
  logic [DIGITS*DW-1:0] win_v, sv;
  logic [DIGITS-1:0] win_en, se;
  logic [DW-1:0] elem;
  logic elem_en, step, wr_ok, wr_bad, live;
  assign full = msg_len == LW'(DEPTH);
  assign empty = msg_len == '0;
  assign scrolling = state == SCROLL;
  assign live = state == SCROLL || state == HOLD;
  assign wr_ok = wr_en && !clear && !live && !full;
  assign wr_bad = wr_en && !clear && !wr_ok;
  scroll_step_gen #(.TICK_M(TICK_M)) u_step (
    .clk   (clk),
    .reset (reset),
    .run_en(state == SCROLL),
    .hold  (state == HOLD),
    .speed (speed),
    .step  (step)
  );
  always_comb begin
    nxt = state;
    if (clear) nxt = IDLE;
    else if (wr_ok) nxt = EDIT;
    else if (state == EDIT) nxt = empty ? IDLE : run ? SCROLL : EDIT;
    else if (state == SCROLL) nxt = !run ? EDIT : pause ? HOLD : SCROLL;
    else if (state == HOLD) nxt = !run ? EDIT : pause ? HOLD : SCROLL;
  end
  // Stream positions at or beyond msg_len are the blank gap; the pointer wraps over len+GAP.
  assign last = PW'(int'(msg_len) + GAP - 1);
  assign ptr_nxt = dir ? (ptr == '0 ? last : ptr - 1'b1) : (ptr == last ? '0 : ptr + 1'b1);
  assign elem_en = int'(ptr) < int'(msg_len);
  assign elem = elem_en ? mem[IW'(ptr)] : '0;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      msg_len <= '0;
      ptr <= '0;
      wr_rej <= 1'b0;
    end else begin
      state <= nxt;
      wr_rej <= wr_bad;
      msg_len <= clear ? '0 : wr_ok ? msg_len + 1'b1 : msg_len;
      if (state == EDIT && nxt == SCROLL) ptr <= dir ? PW'(msg_len - 1'b1) : '0;
      else if (step) ptr <= ptr_nxt;
    end
  always_ff @(posedge clk)
    if (wr_ok) mem[IW'(msg_len)] <= wr_data;
  always_ff @(posedge clk)
    if (reset || !live) begin
      win_v <= '0;
      win_en <= '0;
    end else if (step) begin
      win_v <= dir ? {elem, win_v[DIGITS*DW-1:DW]} : {win_v[DIGITS*DW-DW-1:0], elem};
      win_en <= dir ? {elem_en, win_en[DIGITS-1:1]} : {win_en[DIGITS-2:0], elem_en};
    end
  // Static view: newest character at digit 0, older ones toward higher digits.
  always_comb begin
    sv = '0;
    se = '0;
    for (int i = 0; i < DIGITS; i++)
      if (i < int'(msg_len)) begin
        se[i] = 1'b1;
        sv[i*DW +: DW] = mem[IW'(int'(msg_len) - 1 - i)];
      end
  end
  assign disp_val = live ? win_v : sv;
  assign digit_en = live ? win_en : se;
endmodule

// File: tb/tb_scroll_msg_ctrl.sv
// tb_scroll_msg_ctrl: directed plus randomized checks of scroll_msg_ctrl against a message/stream model.
module tb_scroll_msg_ctrl;
  localparam int DIGITS = 4;
  localparam int DEPTH = 6;
  localparam int DW = 4;
  localparam int GAP = 1;
  localparam int TICK_M = 4;
  typedef enum {M_IDLE, M_EDIT, M_SCROLL, M_HOLD} mode_t;
  logic clk = 0, reset = 1, wr_en = 0, clear = 0, run = 0, pause = 0, dir = 0;
  logic [DW-1:0] wr_data = '0;
  logic [1:0] speed = 2'b00;
  logic [DIGITS*DW-1:0] disp_val;
  logic [DIGITS-1:0] digit_en;
  logic [$clog2(DEPTH+1)-1:0] msg_len;
  logic full, empty, scrolling, wr_rej;
  int n_chk = 0, n_fail = 0;
  int msg[$];
  int w[DIGITS];
  int pos = 0, sc = 0, cur = 0;
  bit m_rej = 0;
  mode_t md = M_IDLE;
  scroll_msg_ctrl #(.DIGITS(DIGITS), .DEPTH(DEPTH), .DW(DW), .GAP(GAP), .TICK_M(TICK_M)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .clear(clear), .run(run),
    .pause(pause), .dir(dir), .speed(speed), .disp_val(disp_val), .digit_en(digit_en),
    .msg_len(msg_len), .full(full), .empty(empty), .scrolling(scrolling), .wr_rej(wr_rej)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic blank_win();
    for (int i = 0; i < DIGITS; i++) w[i] = -1;
  endtask
  // Advance the message stream by one element: characters then GAP blanks, circularly.
  task automatic stream_step();
    int per = msg.size() + GAP;
    int e = pos < msg.size() ? msg[pos] : -1;
    if (!dir) begin
      for (int i = DIGITS - 1; i > 0; i--) w[i] = w[i-1];
      w[0] = e;
      pos = (pos + 1) % per;
    end else begin
      for (int i = 0; i < DIGITS - 1; i++) w[i] = w[i+1];
      w[DIGITS-1] = e;
      pos = (pos + per - 1) % per;
    end
  endtask
  task automatic model_edge();
    bit acc = 0;
    if (reset) begin
      msg.delete();
      md = M_IDLE;
      m_rej = 0;
      sc = 0;
      cur = speed;
      pos = 0;
      blank_win();
      return;
    end
    m_rej = 0;
    if (md == M_SCROLL) begin
      sc++;
      if (sc == (TICK_M << cur)) begin
        sc = 0;
        cur = speed;
        stream_step();
      end
    end else if (md != M_HOLD) begin
      sc = 0;
      cur = speed;
      blank_win();
    end
    if (clear) begin
      msg.delete();
      md = M_IDLE;
    end else begin
      if (wr_en) begin
        if ((md == M_IDLE || md == M_EDIT) && msg.size() < DEPTH) begin
          msg.push_back(int'(wr_data));
          md = M_EDIT;
          acc = 1;
        end else m_rej = 1;
      end
      if (!acc)
        case (md)
          M_EDIT: if (msg.size() == 0) md = M_IDLE;
                  else if (run) begin md = M_SCROLL; pos = dir ? msg.size() - 1 : 0; end
          M_SCROLL: md = !run ? M_EDIT : pause ? M_HOLD : M_SCROLL;
          M_HOLD: md = !run ? M_EDIT : pause ? M_HOLD : M_SCROLL;
          default: ;
        endcase
    end
  endtask
  task automatic compare_all();
    logic [DIGITS*DW-1:0] dv = '0;
    logic [DIGITS-1:0] de = '0;
    int n = msg.size();
    for (int i = 0; i < DIGITS; i++)
      if (md == M_IDLE || md == M_EDIT) begin
        if (i < n) begin de[i] = 1; dv[i*DW +: DW] = DW'(msg[n-1-i]); end
      end else if (w[i] >= 0) begin
        de[i] = 1;
        dv[i*DW +: DW] = DW'(w[i]);
      end
    check("disp_val", 32'(disp_val), 32'(dv));
    check("digit_en", 32'(digit_en), 32'(de));
    check("msg_len", 32'(msg_len), 32'(n));
    check("full", 32'(full), 32'(n == DEPTH));
    check("empty", 32'(empty), 32'(n == 0));
    check("scrolling", 32'(scrolling), 32'(md == M_SCROLL));
    check("wr_rej", 32'(wr_rej), 32'(m_rej));
  endtask
  task automatic tick(input int k = 1);
    repeat (k) begin
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
    end
  endtask
  task automatic wr(input logic [DW-1:0] d);
    wr_en = 1;
    wr_data = d;
    tick();
    wr_en = 0;
  endtask
  initial begin
    tick(2);
    reset = 0;
    check("rst_en", 32'(digit_en), 32'h0);
    check("rst_val", 32'(disp_val), 32'h0);
    wr(4'h1); wr(4'h2); wr(4'h3);
    check("static_val", 32'(disp_val), 32'h0123);
    check("static_en", 32'(digit_en), 32'b0111);
    check("static_len", 32'(msg_len), 32'd3);
    tick(20);
    clear = 1; tick(); clear = 0;
    for (int i = 10; i < 16; i++) wr(DW'(i));
    check("full_set", 32'(full), 32'd1);
    wr(4'h7);
    check("rej_pulse", 32'(wr_rej), 32'd1);
    check("full_len", 32'(msg_len), 32'd6);
    tick();
    check("rej_once", 32'(wr_rej), 32'd0);
    clear = 1; tick(); clear = 0;
    wr(4'h1); wr(4'h2); wr(4'h3);
    speed = 2'b00; dir = 0; run = 1;
    tick();
    check("scroll_blank", 32'(digit_en), 32'h0);
    tick(16);
    check("scroll4_val", 32'(disp_val), 32'h1230);
    check("scroll4_en", 32'(digit_en), 32'b1110);
    pause = 1; tick(20);
    pause = 0; tick(6);
    dir = 1; tick(12);
    speed = 2'b11; tick(80);
    clear = 1; wr_en = 1; wr_data = 4'h9;
    tick();
    clear = 0; wr_en = 0;
    check("clr_en", 32'(digit_en), 32'h0);
    check("clr_len", 32'(msg_len), 32'h0);
    check("clr_rej", 32'(wr_rej), 32'h0);
    run = 0; speed = 2'b00;
    wr(4'h5); wr(4'h6);
    run = 1; tick(15);
    reset = 1; tick();
    reset = 0;
    check("rst_mid_en", 32'(digit_en), 32'h0);
    check("rst_mid_scr", 32'(scrolling), 32'h0);
    run = 0;
    for (int c = 0; c < 3000; c++) begin
      int r = $urandom_range(0, 99);
      wr_en = 0;
      clear = r < 2;
      if (md == M_IDLE || md == M_EDIT) begin
        if (r >= 5 && r < 8) run = 1;
        else if (r >= 8 && r < 10) pause = ~pause;
        else if (r >= 10 && r < 13) dir = ~dir;
        else if (r >= 13 && r < 15) speed = 2'($urandom_range(0, 1));
        if (!run && r >= 20 && r < 50) begin wr_en = 1; wr_data = 4'($urandom); end
      end else begin
        if (r >= 2 && r < 5) pause = ~pause;
        else if (r >= 5 && r < 6) run = 0;
        else if (r >= 6 && r < 9) dir = ~dir;
        else if (r >= 9 && r < 10) speed = 2'($urandom_range(0, 2));
        if (r >= 20 && r < 25 && run && ((md == M_SCROLL && !pause) || (md == M_HOLD && pause))) begin
          wr_en = 1;
          wr_data = 4'($urandom);
        end
      end
      if (clear && r == 0) wr_en = 1;
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/scroll_msg_ctrl.md
Name: scroll_msg_ctrl

Overview:
Parametrised scrolling-message engine for the seven-segment display path. It holds a user-entered message of up to DEPTH characters in an internal register buffer, and shows it statically while editing. On command it scrolls the message circularly across DIGITS positions, with a blank gap between repetitions, a selectable direction, pause and four speeds. The packed output feeds one hex_to_sseg per digit and then disp_mux; digit_en blanks unused positions.

Parameters:
DIGITS, 8, number of display positions
DEPTH, 16, maximum message length in characters
DW, 4, bits per character
GAP, 2, blank positions inserted between message repetitions (0 allowed)
TICK_M, 100000000, clk cycles per base scroll tick

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
wr_en  in  1  single-cycle write strobe (debounced enter tick)
wr_data  in  DW  character to append
clear  in  1  single-cycle strobe; empties message
run  in  1  level; 1 = scroll, 0 = edit
pause  in  1  level; freezes scroll position
dir  in  1  0 = scroll left (new char enters digit 0), 1 = scroll right (enters digit DIGITS-1)
speed  in  2  steps every 1/2/4/8 base ticks for 00/01/10/11
disp_val  out  DIGITS*DW  packed characters, digit 0 in [DW-1:0]
digit_en  out  DIGITS  1 = digit shows a character, 0 = blank
msg_len  out  $clog2(DEPTH+1)  current message length
full  out  1  msg_len == DEPTH
empty  out  1  msg_len == 0
scrolling  out  1  FSM in SCROLL
wr_rej  out  1  one-cycle pulse when a write is ignored

Behaviour:
- Reset takes priority over every input and is sampled on the clk edge. It sets state IDLE, msg_len 0, disp_val 0, digit_en 0, scrolling 0, wr_rej 0, and clears the prescaler, speed divider and read pointer. Buffer contents are don't-care.
- The FSM has four states: IDLE, EDIT, SCROLL, HOLD.
  - IDLE: entered on reset, on clear, or when msg_len is 0. A write goes to EDIT.
  - EDIT: run=1 with msg_len>0 goes to SCROLL.
  - SCROLL: pause=1 goes to HOLD; run=0 goes to EDIT.
  - HOLD: pause=0 goes to SCROLL; run=0 goes to EDIT.
- Priority within a cycle: reset > clear > wr_en > run/pause.
- clear empties the message (msg_len 0), goes to IDLE and blanks the display next cycle. A wr_en in the same cycle is dropped, with no wr_rej.
- Writes:
  - Accepted only in IDLE/EDIT with full=0. The character is stored at index msg_len, and msg_len increments.
  - A write when full, or in SCROLL/HOLD, is ignored and pulses wr_rej for 1 cycle.
- Static view (IDLE/EDIT): the last min(msg_len,DIGITS) characters are right-aligned. The newest character is at digit 0, older characters at higher digits, and the remaining digits are blanked. Both outputs update 1 cycle after the accepted write.
- Entering SCROLL from EDIT:
  - The display first blanks fully (digit_en 0).
  - The read pointer goes to index 0 for dir=0, or msg_len-1 for dir=1.
  - The prescaler and divider restart.
- Step generation: the prescaler counts 0..TICK_M-1 and emits a base tick on wrap. A step occurs every 2^speed base ticks. Both counters run only in SCROLL and hold their values in HOLD.
- Each step shifts the window by one and inserts the next stream element at the entry digit:
  - dir=0: shift toward higher digits; the element enters digit 0.
  - dir=1: shift toward lower digits; the element enters digit DIGITS-1.
  - The stream is the message characters followed by GAP blanks, repeating. dir=0 traverses indices 0..len-1, then the gap. dir=1 traverses len-1..0, then the gap.
  - The pointer wraps modulo len+GAP.
  - disp_val and digit_en update 1 cycle after the step.
- Changing dir mid-scroll takes effect on the next step: the pointer reverses from its current position and the window contents are kept. Changing speed takes effect at the next divider wrap.
- HOLD keeps outputs, the pointer and counters frozen.
- Returning to EDIT restores the static view 1 cycle later.
- Blanked digits always drive disp_val character 0.
- Widths: the pointer is $clog2(DEPTH+GAP) bits. msg_len never exceeds DEPTH.

Decomposition:
- Package scroll_pkg holds:
  - the state enum scroll_state_t (IDLE, EDIT, SCROLL, HOLD);
  - the speed encoding constants;
  - the helper function for pointer width.
- One sub-module, scroll_step_gen, contains the TICK_M prescaler plus the 2^speed divider. Its inputs are run_en and hold; its output is a step pulse.
- The buffer, FSM and window stay in scroll_msg_ctrl.

Test Plan:
1. Bench parameters are DIGITS=4, DEPTH=6, GAP=1, TICK_M=4.
2. Reset, then write 1,2,3 -> msg_len=3 and digit_en=0111. disp_val=0x0123 reads digit3..digit0, with the digit-3 nibble a don't-care 0; the newest char 3 is at digit 0. A step never occurs.
3. Write A..F into 6 entries, then one more write -> full=1, wr_rej pulses once, msg_len stays 6.
4. Message 1,2,3, speed=00, dir=0, run=1 -> display blanks, then each step occurs every 4 clk.
   - Entry order is 1,2,3,blank,1,... into digit 0.
   - After 4 steps, digit3..0 = 1,2,3,blank.
5. Mid-scroll: pause for 20 clk, then release -> no outputs change during the pause, and the next step is 4 clk after release. Set dir=1 -> the next element enters digit 3 and the pointer reverses.
6. Scroll with speed=11 -> step period is 32 clk. Apply clear together with wr_en -> next cycle IDLE, digit_en=0, msg_len=0, wr_rej=0. Assert reset mid-scroll -> all outputs are at reset values the following cycle.
